pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives enable, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Inputs are load-use hazards, taken branches, data-memory wait, exceptions and eret. A small FSM orders these events, holds the exception redirect, and keeps saturating stall/flush statistics.

Parameters:
EXC_HOLD, 1, cycles (>=1) after an exception flush during which PC stays on exception vector and IF/ID is flushed
CNT_W, 16, width of statistic counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_en  in  1  global run enable; 0 freezes pipeline and FSM
id_rs  in  5  rs address of instruction in ID
id_rt  in  5  rt address of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_wr_addr  in  5  destination register of EX instruction
id_branch_taken  in  1  ID resolved a taken jump/branch
mem_busy  in  1  data memory not ready this cycle
exception_req  in  1  exception raised (undefined instr etc.)
eret_req  in  1  eret retiring
pc_en  out  1  PC update enable
pc_sel_exc  out  1  PC takes exception vector
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear
idex_bubble  out  1  ID/EX loads zeros (stall bubble)
idex_flush  out  1  ID/EX clear (exception/eret)
exmem_en  out  1  EX/MEM load enable
exmem_flush  out  1  EX/MEM clear
memwb_en  out  1  MEM/WB load enable
state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 EXC_HOLD
stall_cnt  out  CNT_W  cycles with pc_en=0 while cpu_en=1, saturating
flush_cnt  out  CNT_W  flush events (exception, eret, branch), saturating

Behaviour:
- All control outputs combinational from state + inputs; state and counters registered.
- Reset: state=RUN, hold counter=0, stall_cnt=0, flush_cnt=0. Outputs during rst: all enables 1, all flush/bubble/pc_sel_exc 0.
- cpu_en=0: all enables 0, flush/bubble 0; state, hold counter and statistics unchanged. Inputs ignored.
- Priority per cycle (cpu_en=1, state RUN): exception_req > eret_req > mem_busy > load-use > id_branch_taken.
- load-use = ex_mem_read & ex_wr_addr!=0 & ((id_uses_rs & id_rs==ex_wr_addr) | (id_uses_rt & id_rt==ex_wr_addr)).
- RUN, exception_req: ifid_flush, idex_flush, exmem_flush=1; pc_en=1, pc_sel_exc=1; flush_cnt+1; next EXC_HOLD with counter=EXC_HOLD-1. EXC_HOLD=1 still enters EXC_HOLD for one cycle.
- RUN, eret_req: ifid_flush, idex_flush=1; exmem_flush=0; pc_en=1; flush_cnt+1; stay RUN.
- RUN, mem_busy: pc_en, ifid_en, exmem_en, memwb_en=0; idex ID/EX held (bubble 0); stall_cnt+1; next MEM_WAIT.
- RUN, load-use: pc_en=0, ifid_en=0, idex_bubble=1, others enabled; stall_cnt+1; stay RUN. One bubble per load.
- RUN, branch taken only: ifid_flush=1 (squash delay slot fetch); flush_cnt+1.
- MEM_WAIT: same freeze as RUN/mem_busy while mem_busy=1. When mem_busy=0 this cycle, all enables 1 and next RUN. exception_req in MEM_WAIT is acted on, with RUN-exception behaviour, only once mem_busy=0.
- EXC_HOLD: pc_sel_exc=1, pc_en=1, ifid_flush=1. Counter decrements; at 0, next RUN. exception_req/eret_req ignored. mem_busy freezes counter (no decrement), all enables 0.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset mid-EXC_HOLD or MEM_WAIT returns to RUN next cycle, counters 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_wr_addr=5, id_rs=5, id_uses_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt 0->1; ex_wr_addr=0 gives no stall.
- mem_busy high 3 cycles -> state 1 for 3 cycles, all enables 0, stall_cnt=3; released cycle all enables 1, state 0 next.
- exception_req with EXC_HOLD=3 -> cycle 0 triple flush + pc_sel_exc; then 3 cycles state 2, pc_sel_exc=1, ifid_flush=1; then RUN; flush_cnt=1.
- Simultaneous exception_req, eret_req, load-use, branch -> only exception response; flush_cnt+1, stall_cnt unchanged.
- cpu_en=0 during EXC_HOLD for 4 cycles -> all enables 0, state/counter frozen; resumes remaining hold cycles on cpu_en=1.
- Force stall_cnt to 0xFFFE, 3 stall cycles -> stall_cnt holds 0xFFFF; rst -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: orders exceptions, eret, memory waits,
// load-use hazards and taken branches, and keeps saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int EXC_HOLD = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wr_addr,
    input  logic             id_branch_taken,
    input  logic             mem_busy,
    input  logic             exception_req,
    input  logic             eret_req,
    output logic             pc_en,
    output logic             pc_sel_exc,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_EXC_HOLD = 2'd2
    } state_e;

    localparam int HW = (EXC_HOLD > 1) ? $clog2(EXC_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(EXC_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;
    logic             take_exc;
    logic             flush_evt;

    assign load_use = ex_mem_read && (ex_wr_addr != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_wr_addr)) ||
                       (id_uses_rt && (id_rt == ex_wr_addr)));

    // A pending exception in MEM_WAIT is only taken once memory releases.
    assign take_exc = exception_req &&
                      ((state_q == S_RUN) || ((state_q == S_MEM_WAIT) && !mem_busy));

    always_comb begin
        pc_en       = 1'b1;
        pc_sel_exc  = 1'b0;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        state_d     = state_q;
        hold_d      = hold_q;
        flush_evt   = 1'b0;
        stall_d     = stall_q;
        flush_d     = flush_q;

        if (rst) begin
            state_d = S_RUN;
        end else if (!cpu_en) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (take_exc) begin
            pc_sel_exc  = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
            state_d     = S_EXC_HOLD;
            hold_d      = HOLD_INIT;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (eret_req) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end else if (mem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                        state_d  = S_MEM_WAIT;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_branch_taken) begin
                        ifid_flush = 1'b1;
                        flush_evt  = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_EXC_HOLD: begin
                    pc_sel_exc = 1'b1;
                    if (mem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                    end else begin
                        ifid_flush = 1'b1;
                        if (hold_q == '0) state_d = S_RUN;
                        else              hold_d  = hold_q - HW'(1);
                    end
                end
                default: state_d = S_RUN;
            endcase
        end

        if (!rst && cpu_en && !pc_en && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
        if (flush_evt && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            hold_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (cpu_en) begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
